// File: rtl/pb_event_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_cond_pkg
//  Description : Shared constants, event type and event record for the
//                push-button event conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_cond_pkg;

    localparam int NUM_PB  = 4;
    // Event sources: press0..3 occupy bits 0..3, hold0..3 occupy bits 4..7.
    localparam int NUM_SRC = 2 * NUM_PB;
    localparam int SRC_W   = $clog2(NUM_SRC);

    typedef enum logic {
        EVT_PRESS = 1'b0,
        EVT_HOLD  = 1'b1
    } evt_type_e;

    typedef struct packed {
        evt_type_e  evt_type;
        logic [1:0] idx;
    } pb_evt_t;

    // A source index maps straight onto the event record: the top bit
    // separates presses from holds, the low bits are the button number.
    function automatic pb_evt_t src_to_evt(input logic [SRC_W-1:0] src);
        pb_evt_t evt;
        evt.evt_type = evt_type_e'(src[SRC_W-1]);
        evt.idx      = src[1:0];
        return evt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce_channel
//  Description : One push button: two-flop synchroniser, tick-based
//                symmetric debounce, hold counter, press/hold pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_channel #(
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic pb_n,
    output logic level,
    output logic press,
    output logic hold
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_MS);

    logic          sync_meta;
    logic          sync_q;
    logic          level_q;
    logic          level_next;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_next;
    logic [HW-1:0] hcnt;

    // Bring the asynchronous, inverted button into the clock domain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= ~pb_n;
            sync_q    <= sync_meta;
        end
    end

    // Debounce decision: count ticks of disagreement, flip on the last one.
    always_comb begin
        level_next = level_q;
        dcnt_next  = dcnt;
        if (tick) begin
            if (sync_q != level_q) begin
                if (dcnt == DCNT_LAST) begin
                    level_next = ~level_q;
                    dcnt_next  = '0;
                end else begin
                    dcnt_next  = dcnt + 1'b1;
                end
            end else begin
                dcnt_next = '0;
            end
        end
    end

    // Debounced level and press pulse; the pulse is registered alongside
    // the level so both rise in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_q <= 1'b0;
            dcnt    <= '0;
            press   <= 1'b0;
        end else begin
            level_q <= level_next;
            dcnt    <= dcnt_next;
            press   <= level_next & ~level_q;
        end
    end

    // Hold counter saturates so exactly one hold pulse fires per press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hcnt <= '0;
            hold <= 1'b0;
        end else begin
            hold <= level_q & tick & (hcnt == HCNT_LAST);
            if (!level_q) begin
                hcnt <= '0;
            end else if (tick && (hcnt != HCNT_MAX)) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/pb_event_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pb_event_conditioner
//  Description : Debounces four active-low push buttons, emits press/hold
//                pulses and queues them through a show-ahead event FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_event_conditioner
    import pb_cond_pkg::*;
#(
    parameter int TICK_CYCLES = 50000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  CLOCK_50_I,
    input  logic                  resetn,
    input  logic [NUM_PB-1:0]     PUSH_BUTTON_N_I,
    output logic                  tick_1ms_o,
    output logic [NUM_PB-1:0]     pb_level_o,
    output logic [NUM_PB-1:0]     pb_press_o,
    output logic [NUM_PB-1:0]     pb_hold_o,
    output logic                  evt_valid_o,
    output logic [$bits(pb_evt_t)-1:0] evt_data_o,
    input  logic                  evt_ready_i,
    output logic                  evt_overflow_o
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [NUM_SRC-1:0] events;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   grant_src;
    logic               grant_any;
    logic               fifo_full;
    logic               pop;
    pb_evt_t            mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Free-running divider producing the debounce tick.
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick       = (tick_cnt == TICK_LAST);
    assign tick_1ms_o = tick;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
        pb_debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .HOLD_MS     (HOLD_MS)
        ) u_chan (
            .clk    (CLOCK_50_I),
            .resetn (resetn),
            .tick   (tick),
            .pb_n   (PUSH_BUTTON_N_I[i]),
            .level  (pb_level_o[i]),
            .press  (pb_press_o[i]),
            .hold   (pb_hold_o[i])
        );
    end

    assign events = {pb_hold_o, pb_press_o};

    // Fixed-priority pick of the lowest pending source while the FIFO has room.
    always_comb begin
        grant     = '0;
        grant_src = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pending[k] && !grant_any && !fifo_full) begin
                grant_any = 1'b1;
                grant_src = SRC_W'(k);
                grant[k]  = 1'b1;
            end
        end
    end

    // Pending bits collect pulses; a pulse landing on an occupied bit is lost.
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            pending        <= '0;
            evt_overflow_o <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | (events & ~pending);
            if (|(events & pending)) begin
                evt_overflow_o <= 1'b1;
            end
        end
    end

    // Fullness uses the registered count only: a pop never frees a slot
    // for a push in the same cycle.
    assign fifo_full   = (count == CNT_FULL);
    assign evt_valid_o = (count != '0);
    assign pop         = evt_valid_o & evt_ready_i;
    assign evt_data_o  = mem[rd_ptr];

    // Show-ahead event FIFO storage, pointers and occupancy.
    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                mem[wr_ptr] <= src_to_evt(grant_src);
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (grant_any && !pop) begin
                count <= count + 1'b1;
            end else if (!grant_any && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_event_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_event_conditioner
//  Description : Directed self-checking bench for pb_event_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_event_conditioner;

    localparam int TICK_CYCLES = 10;
    localparam int DEBOUNCE_MS = 3;
    localparam int HOLD_MS     = 8;
    localparam int FIFO_DEPTH  = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] pb_n;
    logic       tick_1ms;
    logic [3:0] pb_level;
    logic [3:0] pb_press;
    logic [3:0] pb_hold;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       evt_ready;
    logic       evt_overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int press_cnt [4] = '{default: 0};
    int hold_cnt  [4] = '{default: 0};
    int press_cyc [4] = '{default: 0};
    int hold_cyc  [4] = '{default: 0};
    logic [2:0] popq [$];
    int         popc [$];

    always #5 clk = ~clk;

    pb_event_conditioner #(
        .TICK_CYCLES (TICK_CYCLES),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .HOLD_MS     (HOLD_MS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLOCK_50_I      (clk),
        .resetn          (resetn),
        .PUSH_BUTTON_N_I (pb_n),
        .tick_1ms_o      (tick_1ms),
        .pb_level_o      (pb_level),
        .pb_press_o      (pb_press),
        .pb_hold_o       (pb_hold),
        .evt_valid_o     (evt_valid),
        .evt_data_o      (evt_data),
        .evt_ready_i     (evt_ready),
        .evt_overflow_o  (evt_overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record pulses and accepted events mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pb_press[i] === 1'b1) begin
                press_cnt[i] = press_cnt[i] + 1;
                press_cyc[i] = cyc;
            end
            if (pb_hold[i] === 1'b1) begin
                hold_cnt[i] = hold_cnt[i] + 1;
                hold_cyc[i] = cyc;
            end
        end
        if (resetn && evt_valid && evt_ready) begin
            popq.push_back(evt_data);
            popc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Missing entries read as 3'b111, which no scenario expects.
    function automatic logic [2:0] pop_at(input int k);
        if (k < popq.size()) return popq[k];
        return 3'b111;
    endfunction

    initial begin
        int n;
        int b;
        int pc;
        int hc;

        pb_n      = 4'hF;
        evt_ready = 1'b0;
        resetn    = 1'b0;
        steps(3);

        // Reset state
        check_eq("rst_level",    pb_level,     0);
        check_eq("rst_press",    pb_press,     0);
        check_eq("rst_hold",     pb_hold,      0);
        check_eq("rst_valid",    evt_valid,    0);
        check_eq("rst_data",     evt_data,     0);
        check_eq("rst_overflow", evt_overflow, 0);
        check_eq("rst_tick",     tick_1ms,     0);
        resetn = 1'b1;

        // Clean press on PB0, aligned to a tick cycle
        evt_ready = 1'b1;
        b  = popq.size();
        pc = press_cnt[0];
        n  = 0;
        while (!tick_1ms && n < 20) begin step(); n++; end
        check_eq("align_tick", tick_1ms, 1);
        pb_n[0] = 1'b0;
        n = 0;
        while (!pb_level[0] && n < 50) begin step(); n++; end
        check_eq("press_latency", n, 31);
        check_eq("press_pulse", pb_press[0], 1);
        step();
        check_eq("press_p1_pulse", pb_press[0], 0);
        check_eq("press_p1_valid", evt_valid, 0);
        step();
        check_eq("press_p2_valid", evt_valid, 1);
        check_eq("press_p2_data", evt_data, 3'b000);
        step();
        check_eq("press_p3_valid", evt_valid, 0);
        pb_n[0] = 1'b1;
        steps(50);
        check_eq("release_level", pb_level[0], 0);
        check_eq("clean_press_cnt", press_cnt[0] - pc, 1);
        check_eq("clean_pop_cnt", popq.size() - b, 1);

        // Bounce on PB1: never stable for three ticks
        b  = popq.size();
        pc = press_cnt[1];
        for (int k = 0; k < 14; k++) begin
            pb_n[1] = (k % 2 != 0);
            steps(15);
        end
        pb_n[1] = 1'b1;
        steps(50);
        check_eq("bounce_level", pb_level[1], 0);
        check_eq("bounce_press_cnt", press_cnt[1] - pc, 0);
        check_eq("bounce_pop_cnt", popq.size() - b, 0);

        // Hold on PB2
        b  = popq.size();
        pc = press_cnt[2];
        hc = hold_cnt[2];
        pb_n[2] = 1'b0;
        steps(150);
        pb_n[2] = 1'b1;
        steps(50);
        check_eq("hold_press_cnt", press_cnt[2] - pc, 1);
        check_eq("hold_hold_cnt", hold_cnt[2] - hc, 1);
        check_eq("hold_latency", hold_cyc[2] - press_cyc[2], 80);
        check_eq("hold_pop_cnt", popq.size() - b, 2);
        check_eq("hold_evt0", pop_at(b), 3'b010);
        check_eq("hold_evt1", pop_at(b + 1), 3'b110);

        // Simultaneous presses on all buttons
        b = popq.size();
        pb_n = 4'h0;
        steps(45);
        check_eq("simul_same_cycle", press_cyc[3] - press_cyc[0], 0);
        check_eq("simul_pop_cnt", popq.size() - b, 4);
        check_eq("simul_evt0", pop_at(b),     3'b000);
        check_eq("simul_evt1", pop_at(b + 1), 3'b001);
        check_eq("simul_evt2", pop_at(b + 2), 3'b010);
        check_eq("simul_evt3", pop_at(b + 3), 3'b011);
        if (popc.size() >= b + 4)
            check_eq("simul_consecutive", popc[b + 3] - popc[b], 3);
        else
            check_eq("simul_consecutive", popc.size(), b + 4);
        pb_n = 4'hF;
        steps(50);

        // Overflow with a stalled consumer
        evt_ready = 1'b0;
        b = popq.size();
        pb_n = 4'h0;
        steps(45);
        pb_n = 4'hF;
        steps(50);
        check_eq("ovf_full_valid", evt_valid, 1);
        check_eq("ovf_before", evt_overflow, 0);
        pb_n[0] = 1'b0;
        steps(45);
        pb_n[0] = 1'b1;
        steps(50);
        check_eq("ovf_pending_only", evt_overflow, 0);
        check_eq("ovf_no_pops", popq.size() - b, 0);
        pb_n[0] = 1'b0;
        steps(45);
        check_eq("ovf_set", evt_overflow, 1);
        pb_n[0] = 1'b1;
        steps(50);
        check_eq("ovf_sticky", evt_overflow, 1);
        evt_ready = 1'b1;
        steps(10);
        check_eq("ovf_pop_cnt", popq.size() - b, 5);
        check_eq("ovf_evt0", pop_at(b),     3'b000);
        check_eq("ovf_evt1", pop_at(b + 1), 3'b001);
        check_eq("ovf_evt2", pop_at(b + 2), 3'b010);
        check_eq("ovf_evt3", pop_at(b + 3), 3'b011);
        check_eq("ovf_evt4", pop_at(b + 4), 3'b000);
        check_eq("ovf_drained", evt_valid, 0);
        check_eq("ovf_still_set", evt_overflow, 1);

        // Reset while PB3 is held
        pb_n[3] = 1'b0;
        steps(45);
        check_eq("mid_level_before", pb_level[3], 1);
        resetn = 1'b0;
        step();
        check_eq("mid_rst_level",    pb_level,     0);
        check_eq("mid_rst_press",    pb_press,     0);
        check_eq("mid_rst_hold",     pb_hold,      0);
        check_eq("mid_rst_valid",    evt_valid,    0);
        check_eq("mid_rst_overflow", evt_overflow, 0);
        check_eq("mid_rst_tick",     tick_1ms,     0);
        resetn = 1'b1;
        n = 0;
        while (!pb_press[3] && n < 50) begin
            step();
            n++;
            if (n == 9) check_eq("mid_first_tick", tick_1ms, 1);
        end
        check_eq("mid_repress_latency", n, 30);
        pb_n = 4'hF;
        steps(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
